// File: rtl/ps2_frame_rx_pkg.sv
// Shared PS/2 definitions: framing constants, receiver states and the
// scancodes the downstream key mapper cares about.
package ps2_pkg;

  localparam logic [7:0]  PS2_EXT        = 8'hE0;
  localparam logic [7:0]  PS2_BRK        = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

  localparam logic [7:0] W     = 8'h1D;
  localparam logic [7:0] A     = 8'h1C;
  localparam logic [7:0] S     = 8'h1B;
  localparam logic [7:0] D     = 8'h23;
  localparam logic [7:0] SPACE = 8'h29;
  localparam logic [7:0] TAB   = 8'h0D;
  localparam logic [7:0] UP    = 8'h75;
  localparam logic [7:0] DOWN  = 8'h72;
  localparam logic [7:0] LEFT  = 8'h6B;
  localparam logic [7:0] RIGHT = 8'h74;

  // Data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_frame_rx_if.sv
// PS/2 receiver bus: raw keyboard pins in, qualified scancode events out.
// master = keyboard/stimulus side, slave = receiver side.
interface ps2_frame_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  modport master (
    output ps2_clk, ps2_data,
    input  code, code_valid, is_break, is_extended, frame_err, busy
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output code, code_valid, is_break, is_extended, frame_err, busy
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a persistence filter for one PS/2 line.
// Also provides a falling-edge strobe of the filtered level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic filt,
  output logic fe
);

  logic       sync_a;
  logic       sync_b;
  logic       level;
  logic       level_prev;
  logic [7:0] cnt;

  // Synchronise the asynchronous pin; preset high to match an idle bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Flip the filtered level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b1;
      cnt   <= '0;
    end else if (sync_b != level) begin
      if (cnt == 8'(FILTER_LEN - 1)) begin
        level <= sync_b;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else begin
      cnt <= '0;
    end
  end

  // Remember last cycle's filtered level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_prev <= 1'b1;
    else     level_prev <= level;
  end

  assign filt = level;
  assign fe   = level_prev & ~level;

endmodule

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver. Deserialises 11-bit frames, checks
// start/parity/stop, and folds E0/F0 prefixes into flags on the next code.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic           clk,
  input  logic           rst,
  ps2_frame_rx_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

  state_e        state;
  logic [3:0]    bitcnt;
  logic [10:0]   shreg;
  logic [TW-1:0] timer;
  logic          ext_flag;
  logic          brk_flag;
  logic [7:0]    code;
  logic          code_valid;
  logic          is_break;
  logic          is_extended;
  logic          frame_err;

  logic          clk_f;
  logic          fe;
  logic          data_f;
  logic          unused_data_fe;
  logic          unused_clk_level;
  logic [7:0]    rx_byte;
  logic          frame_ok;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.ps2_clk),
    .filt (clk_f),
    .fe   (fe)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk  (clk),
    .rst  (rst),
    .raw  (bus.ps2_data),
    .filt (data_f),
    .fe   (unused_data_fe)
  );

  assign unused_clk_level = clk_f;

  // shreg[0] = start, [8:1] = data LSB first, [9] = parity, [10] = stop.
  assign rx_byte  = shreg[8:1];
  assign frame_ok = ~shreg[0] & shreg[10] & odd_parity_ok(shreg[9:1]);

  // Frame FSM with registered event outputs and prefix flag tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      bitcnt      <= '0;
      shreg       <= '0;
      timer       <= '0;
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      code        <= '0;
      code_valid  <= 1'b0;
      is_break    <= 1'b0;
      is_extended <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge with data high is a spurious edge, not a start bit.
          if (fe && !data_f) begin
            state  <= RECV;
            bitcnt <= 4'd1;
            timer  <= '0;
            shreg  <= {data_f, shreg[10:1]};
          end
        end
        RECV: begin
          // An edge takes priority over a coincident timeout.
          if (fe) begin
            shreg  <= {data_f, shreg[10:1]};
            bitcnt <= bitcnt + 4'd1;
            timer  <= '0;
            if (bitcnt == 4'(PS2_FRAME_BITS - 1)) state <= CHECK;
          end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            bitcnt    <= '0;
            shreg     <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHECK: begin
          state  <= IDLE;
          bitcnt <= '0;
          if (!frame_ok) begin
            frame_err <= 1'b1;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
          end else if (rx_byte == PS2_EXT) begin
            ext_flag <= 1'b1;
          end else if (rx_byte == PS2_BRK) begin
            brk_flag <= 1'b1;
          end else begin
            code        <= rx_byte;
            is_break    <= brk_flag;
            is_extended <= ext_flag;
            code_valid  <= 1'b1;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.code        = code;
  assign bus.code_valid  = code_valid;
  assign bus.is_break    = is_break;
  assign bus.is_extended = is_extended;
  assign bus.frame_err   = frame_err;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: a keyboard model drives frames, expected
// events go into a scoreboard queue and are checked when the DUT emits them.
module tb_ps2_frame_rx;
  import ps2_pkg::*;

  localparam int unsigned FLEN = 8;
  localparam int unsigned TOUT = 400;
  localparam int          H    = 40;  // half bit period in clk cycles

  typedef struct packed {
    logic       is_err;
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } exp_t;

  logic clk;
  logic rst;
  ps2_frame_rx_if bus ();

  ps2_frame_rx #(.FILTER_LEN(FLEN), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t got;
  int   cyc = 0;
  int   last_fe = 0;

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_code(input logic [7:0] c, input logic brk, input logic ext);
    sb.push_back({1'b0, c, brk, ext});
  endtask

  task automatic expect_err();
    sb.push_back({1'b1, 8'h00, 1'b0, 1'b0});
  endtask

  // Drive the first n bits of frame f; gmask puts a low glitch of glen
  // cycles into the high phase just before the selected bits' falling edge.
  task automatic send_bits(input logic [10:0] f, input int n, input logic [10:0] gmask,
                           input int glen);
    for (int i = 0; i < n; i++) begin
      bus.ps2_data = f[i];
      if (gmask[i]) begin
        repeat (15) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (glen) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (H - 15 - glen) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      bus.ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] b, input logic flip);
    return {1'b1, ~(^b) ^ flip, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input logic flip, input logic [10:0] gmask,
                            input int glen);
    send_bits(frame_of(b, flip), 11, gmask, glen);
    repeat (3 * H) @(negedge clk);
  endtask

  // Cycle counter and reference time of the last clock falling edge seen by the FSM.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (dut.u_clk_filt.fe) last_fe <= cyc + 1;
  end

  // Scoreboard: every output event must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && (bus.code_valid || bus.frame_err)) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(sb.size()), 32'd1);
      end else begin
        got = sb.pop_front();
        chk("ev_frame_err", 32'(bus.frame_err), 32'(got.is_err));
        chk("ev_code_valid", 32'(bus.code_valid), 32'(!got.is_err));
        if (!got.is_err) begin
          chk("ev_code", 32'(bus.code), 32'(got.code));
          chk("ev_is_break", 32'(bus.is_break), 32'(got.brk));
          chk("ev_is_extended", 32'(bus.is_extended), 32'(got.ext));
        end
      end
    end
  end

  initial begin
    logic seen;
    rst          = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_code", 32'(bus.code), 32'd0);
    chk("rst_code_valid", 32'(bus.code_valid), 32'd0);
    chk("rst_is_break", 32'(bus.is_break), 32'd0);
    chk("rst_is_extended", 32'(bus.is_extended), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Make, break of W.
    expect_code(W, 1'b0, 1'b0);
    send_frame(W, 1'b0, '0, 0);
    send_frame(PS2_BRK, 1'b0, '0, 0);
    expect_code(W, 1'b1, 1'b0);
    send_frame(W, 1'b0, '0, 0);
    chk("sb_empty_w", 32'(sb.size()), 32'd0);
    chk("hold_code", 32'(bus.code), 32'(W));
    chk("hold_is_break", 32'(bus.is_break), 32'd1);

    // Extended make, then extended break.
    send_frame(PS2_EXT, 1'b0, '0, 0);
    expect_code(UP, 1'b0, 1'b1);
    send_frame(UP, 1'b0, '0, 0);
    send_frame(PS2_EXT, 1'b0, '0, 0);
    send_frame(PS2_BRK, 1'b0, '0, 0);
    expect_code(UP, 1'b1, 1'b1);
    send_frame(UP, 1'b0, '0, 0);
    chk("sb_empty_up", 32'(sb.size()), 32'd0);

    // Bad parity then a clean frame.
    expect_err();
    send_frame(SPACE, 1'b1, '0, 0);
    expect_code(SPACE, 1'b0, 1'b0);
    send_frame(SPACE, 1'b0, '0, 0);
    chk("sb_empty_space", 32'(sb.size()), 32'd0);

    // Timeout after 5 bits; the pending F0 flag survives it.
    send_frame(PS2_BRK, 1'b0, '0, 0);
    send_bits(frame_of(A, 1'b0), 5, '0, 0);
    chk("busy_mid_frame", 32'(bus.busy), 32'd1);
    expect_err();
    for (int k = 0; k < int'(TOUT) + 100 && !bus.frame_err; k++) @(negedge clk);
    seen = bus.frame_err;
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_latency", 32'(cyc - last_fe), 32'(TOUT));
    chk("timeout_busy", 32'(bus.busy), 32'd0);
    repeat (H) @(negedge clk);
    expect_code(A, 1'b1, 1'b0);
    send_frame(A, 1'b0, '0, 0);
    chk("sb_empty_a", 32'(sb.size()), 32'd0);

    // Short clock glitches are filtered; a long one adds an edge and breaks framing.
    expect_code(D, 1'b0, 1'b0);
    send_frame(D, 1'b0, 11'b010_0010_0100, 3);
    expect_err();
    send_frame(D, 1'b0, 11'b000_0000_1000, 10);
    chk("sb_empty_d", 32'(sb.size()), 32'd0);

    // Reset in the middle of a frame (after a pending F0).
    send_frame(PS2_BRK, 1'b0, '0, 0);
    send_bits(frame_of(LEFT, 1'b0), 7, '0, 0);
    chk("busy_before_rst", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_code", 32'(bus.code), 32'd0);
    chk("midrst_is_break", 32'(bus.is_break), 32'd0);
    chk("midrst_is_extended", 32'(bus.is_extended), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (H) @(negedge clk);
    expect_code(LEFT, 1'b0, 1'b0);
    send_frame(LEFT, 1'b0, '0, 0);

    chk("sb_empty_final", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
